// File: rtl/bubble_sort_ctrl.sv
// Control stage for an in-place ascending bubble sort.
// Sequences the outer (pass) and inner (compare) index counters, compares the
// adjacent register-file words at j and j+1, and issues swap writes. A sort
// ends after the last pass, or earlier after a pass that performed no swap.
module bubble_sort_ctrl #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int LEN = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   i_q,
    input  logic [N-1:0]   j_q,
    input  logic [W-1:0]   rd_a,
    input  logic [W-1:0]   rd_b,
    output logic           i_ld,
    output logic           i_en,
    output logic [N-1:0]   i_d,
    output logic           j_ld,
    output logic           j_en,
    output logic [N-1:0]   j_d,
    output logic           wr_en,
    output logic [W-1:0]   wr_data_a,
    output logic [W-1:0]   wr_data_b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] cmp_cnt,
    output logic [2*N-1:0] swap_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Index of the last pass, and of the last compare in pass 0. One extra bit
    // keeps LEN-2-i_q from wrapping when LEN == 2**N.
    localparam logic [N:0] LAST = (N+1)'(LEN - 2);

    state_t         state_q, state_d;
    logic [2*N-1:0] cmp_cnt_q, cmp_cnt_d;
    logic [2*N-1:0] swap_cnt_q, swap_cnt_d;
    logic           swapped_q, swapped_d;

    logic           gt_s;
    logic           end_pass_s;
    logic           last_pass_s;
    logic           finish_s;

    assign gt_s        = (rd_a > rd_b);
    assign end_pass_s  = ({1'b0, j_q} == (LAST - {1'b0, i_q}));
    assign last_pass_s = ({1'b0, i_q} == LAST);
    // Sort is complete at the end of the final pass, or at the end of any pass
    // with no swap (the current compare counts toward this pass).
    assign finish_s    = end_pass_s && (last_pass_s || !(swapped_q || gt_s));

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmp_cnt_q  <= '0;
            swap_cnt_q <= '0;
            swapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmp_cnt_q  <= cmp_cnt_d;
            swap_cnt_q <= swap_cnt_d;
            swapped_q  <= swapped_d;
        end
    end

    // Next-state and statistics update.
    always_comb begin
        state_d    = state_q;
        cmp_cnt_d  = cmp_cnt_q;
        swap_cnt_d = swap_cnt_q;
        swapped_d  = swapped_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_INIT;
                    cmp_cnt_d  = '0;
                    swap_cnt_d = '0;
                    swapped_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                cmp_cnt_d = cmp_cnt_q + (2*N)'(1);
                if (gt_s) begin
                    swap_cnt_d = swap_cnt_q + (2*N)'(1);
                    swapped_d  = 1'b1;
                end else begin
                    swap_cnt_d = swap_cnt_q;
                end
                if (!end_pass_s) begin
                    state_d = S_CMP;
                end else if (finish_s) begin
                    state_d = S_DONE;
                end else begin
                    // New pass starts with a clean swap flag.
                    swapped_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Counter and write strobes, decoded from state and the current compare.
    always_comb begin
        i_ld  = 1'b0;
        i_en  = 1'b0;
        j_ld  = 1'b0;
        j_en  = 1'b0;
        wr_en = 1'b0;
        case (state_q)
            S_INIT: begin
                i_ld = 1'b1;
                j_ld = 1'b1;
            end
            S_CMP: begin
                wr_en = gt_s;
                if (!end_pass_s) begin
                    j_en = 1'b1;
                end else if (!finish_s) begin
                    i_en = 1'b1;
                    j_ld = 1'b1;
                end else begin
                    i_en = 1'b0;
                end
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Both counters always restart from index 0.
    assign i_d       = '0;
    assign j_d       = '0;
    assign wr_data_a = wr_en ? rd_b : '0;
    assign wr_data_b = wr_en ? rd_a : '0;
    assign busy      = (state_q == S_INIT) || (state_q == S_CMP);
    assign done      = (state_q == S_DONE);
    assign cmp_cnt   = cmp_cnt_q;
    assign swap_cnt  = swap_cnt_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: models the index counters and register file,
// runs directed sorts and checks results, counts and timing.
module tb_bubble_sort_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Main instance: N=4, W=8, LEN=4
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] i_q = 4'd0;
    logic [3:0] j_q = 4'd0;
    logic [7:0] mem [0:15];
    logic [7:0] rd_a, rd_b;
    logic       i_ld, i_en, j_ld, j_en, wr_en, busy, done;
    logic [3:0] i_d, j_d;
    logic [7:0] wr_data_a, wr_data_b;
    logic [7:0] cmp_cnt, swap_cnt;

    logic       load_req = 1'b0;
    logic [7:0] init_vals [0:3];

    assign rd_a = mem[j_q];
    assign rd_b = mem[j_q + 4'd1];

    bubble_sort_ctrl #(.N(4), .W(8), .LEN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .i_q(i_q), .j_q(j_q),
        .rd_a(rd_a), .rd_b(rd_b), .i_ld(i_ld), .i_en(i_en), .i_d(i_d),
        .j_ld(j_ld), .j_en(j_en), .j_d(j_d), .wr_en(wr_en),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .busy(busy),
        .done(done), .cmp_cnt(cmp_cnt), .swap_cnt(swap_cnt)
    );

    // Counter and register-file models for the main instance.
    always @(posedge clk) begin
        if (i_ld) i_q <= i_d;
        else if (i_en) i_q <= i_q + 4'd1;
        if (j_ld) j_q <= j_d;
        else if (j_en) j_q <= j_q + 4'd1;
        if (load_req) begin
            for (int k = 0; k < 16; k++) mem[k] <= (k < 4) ? init_vals[k] : 8'd0;
        end else if (wr_en) begin
            mem[j_q]        <= wr_data_a;
            mem[j_q + 4'd1] <= wr_data_b;
        end
    end

    // Second instance: N=1, LEN=2
    logic       start2 = 1'b0;
    logic [0:0] i2_q = 1'b0;
    logic [0:0] j2_q = 1'b0;
    logic [7:0] mem2 [0:1];
    logic [7:0] rd_a2, rd_b2;
    logic       i2_ld, i2_en, j2_ld, j2_en, wr2_en, busy2, done2;
    logic [0:0] i2_d, j2_d;
    logic [7:0] wr2_data_a, wr2_data_b;
    logic [1:0] cmp_cnt2, swap_cnt2;

    assign rd_a2 = mem2[j2_q];
    assign rd_b2 = mem2[j2_q + 1'b1];

    bubble_sort_ctrl #(.N(1), .W(8), .LEN(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .i_q(i2_q), .j_q(j2_q),
        .rd_a(rd_a2), .rd_b(rd_b2), .i_ld(i2_ld), .i_en(i2_en), .i_d(i2_d),
        .j_ld(j2_ld), .j_en(j2_en), .j_d(j2_d), .wr_en(wr2_en),
        .wr_data_a(wr2_data_a), .wr_data_b(wr2_data_b), .busy(busy2),
        .done(done2), .cmp_cnt(cmp_cnt2), .swap_cnt(swap_cnt2)
    );

    // Counter and register-file models for the LEN=2 instance.
    always @(posedge clk) begin
        if (i2_ld) i2_q <= i2_d;
        else if (i2_en) i2_q <= i2_q + 1'b1;
        if (j2_ld) j2_q <= j2_d;
        else if (j2_en) j2_q <= j2_q + 1'b1;
        if (load_req) begin
            mem2[0] <= init_vals[0];
            mem2[1] <= init_vals[1];
        end else if (wr2_en) begin
            mem2[j2_q]        <= wr2_data_a;
            mem2[j2_q + 1'b1] <= wr2_data_b;
        end
    end

    task automatic load4(input logic [7:0] a, b, c, d);
        @(negedge clk);
        init_vals[0] = a; init_vals[1] = b; init_vals[2] = c; init_vals[3] = d;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Pulses (or holds) start, then follows the sort cycle by cycle. dcyc is the
    // cycle with done high (cycle 0 = start sampled), -1 on timeout. viol counts
    // protocol breaches: write on equal words, wrong write data, ld+en together,
    // busy low before done or high with done.
    task automatic do_sort(input bit hold, output int dcyc, output int viol);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        dcyc = -1;
        viol = 0;
        for (int k = 1; k < 200; k++) begin
            if (k > 1) @(negedge clk);
            if (wr_en && (rd_a == rd_b)) viol++;
            if (wr_en && ((wr_data_a !== rd_b) || (wr_data_b !== rd_a))) viol++;
            if ((i_ld && i_en) || (j_ld && j_en)) viol++;
            if (done) begin
                dcyc = k;
                if (busy !== 1'b0) viol++;
                break;
            end
            if (busy !== 1'b1) viol++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, i_ld, i_en, j_ld, j_en, wr_en} !== 7'b0) begin
            fails++;
            $display("FAIL reset_strobes: got %b, want 0000000", {busy, done, i_ld, i_en, j_ld, j_en, wr_en});
        end
        tests++;
        if ({cmp_cnt, swap_cnt, wr_data_a, wr_data_b, i_d, j_d} !== 40'd0) begin
            fails++;
            $display("FAIL reset_values: cmp=%0d swap=%0d wa=%h wb=%h id=%0d jd=%0d, want all 0",
                     cmp_cnt, swap_cnt, wr_data_a, wr_data_b, i_d, j_d);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int dc, v;
        load4(8'd3, 8'd1, 8'd2, 8'd0);
        do_sort(1'b0, dc, v);
        tests++;
        if (dc !== 8) begin fails++; $display("FAIL basic_done_cycle: got %0d, want 8", dc); end
        tests++;
        if (v !== 0) begin fails++; $display("FAIL basic_protocol: got %0d violations, want 0", v); end
        tests++;
        if (cmp_cnt !== 8'd6 || swap_cnt !== 8'd5) begin
            fails++; $display("FAIL basic_counts: got cmp=%0d swap=%0d, want 6/5", cmp_cnt, swap_cnt);
        end
        @(negedge clk);
        tests++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h00010203) begin
            fails++; $display("FAIL basic_data: got %h, want 00010203", {mem[0], mem[1], mem[2], mem[3]});
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL basic_done_pulse: busy=%b done=%b after DONE, want 0/0", busy, done);
        end
    endtask

    task automatic test_sorted;
        int dc, v;
        load4(8'd0, 8'd1, 8'd2, 8'd3);
        do_sort(1'b0, dc, v);
        tests++;
        if (dc !== 5) begin fails++; $display("FAIL sorted_done_cycle: got %0d, want 5", dc); end
        tests++;
        if (cmp_cnt !== 8'd3 || swap_cnt !== 8'd0 || v !== 0) begin
            fails++; $display("FAIL sorted_counts: got cmp=%0d swap=%0d viol=%0d, want 3/0/0", cmp_cnt, swap_cnt, v);
        end
        @(negedge clk);
        tests++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h00010203) begin
            fails++; $display("FAIL sorted_data: got %h, want 00010203", {mem[0], mem[1], mem[2], mem[3]});
        end
    endtask

    task automatic test_duplicates;
        int dc, v;
        load4(8'd2, 8'd2, 8'd1, 8'd1);
        do_sort(1'b0, dc, v);
        tests++;
        if (v !== 0 || dc !== 8) begin
            fails++; $display("FAIL dup_protocol: got viol=%0d done_cycle=%0d, want 0/8", v, dc);
        end
        tests++;
        if (cmp_cnt !== 8'd6 || swap_cnt !== 8'd4) begin
            fails++; $display("FAIL dup_counts: got cmp=%0d swap=%0d, want 6/4", cmp_cnt, swap_cnt);
        end
        @(negedge clk);
        tests++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h01010202) begin
            fails++; $display("FAIL dup_data: got %h, want 01010202", {mem[0], mem[1], mem[2], mem[3]});
        end
    endtask

    task automatic test_unsigned;
        int dc, v;
        load4(8'hFF, 8'h00, 8'h80, 8'h7F);
        do_sort(1'b0, dc, v);
        tests++;
        if (cmp_cnt !== 8'd6 || swap_cnt !== 8'd4 || v !== 0) begin
            fails++; $display("FAIL unsigned_counts: got cmp=%0d swap=%0d viol=%0d, want 6/4/0", cmp_cnt, swap_cnt, v);
        end
        @(negedge clk);
        tests++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h007F80FF) begin
            fails++; $display("FAIL unsigned_data: got %h, want 007F80FF", {mem[0], mem[1], mem[2], mem[3]});
        end
    endtask

    task automatic test_len2;
        int dc;
        load4(8'd9, 8'd4, 8'd0, 8'd0);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        dc = -1;
        for (int k = 1; k < 50; k++) begin
            if (k > 1) @(negedge clk);
            if (done2) begin dc = k; break; end
        end
        tests++;
        if (dc !== 3) begin fails++; $display("FAIL len2_done_cycle: got %0d, want 3", dc); end
        tests++;
        if (cmp_cnt2 !== 2'd1 || swap_cnt2 !== 2'd1) begin
            fails++; $display("FAIL len2_counts: got cmp=%0d swap=%0d, want 1/1", cmp_cnt2, swap_cnt2);
        end
        @(negedge clk);
        tests++;
        if ({mem2[0], mem2[1]} !== 16'h0409) begin
            fails++; $display("FAIL len2_data: got %h, want 0409", {mem2[0], mem2[1]});
        end
    endtask

    task automatic test_reset_mid;
        int dc, v;
        bit hit;
        load4(8'd3, 8'd1, 8'd2, 8'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (busy && !i_ld && i_q == 4'd1) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL rst_mid_reach: pass 1 got not reached, want reached"); end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, i_ld, i_en, j_ld, j_en, wr_en} !== 7'b0 || cmp_cnt !== 8'd0 || swap_cnt !== 8'd0) begin
            fails++; $display("FAIL rst_mid_outputs: got %b cmp=%0d swap=%0d, want 0000000 0/0",
                              {busy, done, i_ld, i_en, j_ld, j_en, wr_en}, cmp_cnt, swap_cnt);
        end
        rst = 1'b0;
        // File was [1,2,0,3] when the sort was aborted.
        do_sort(1'b0, dc, v);
        tests++;
        if (dc !== 8 || cmp_cnt !== 8'd6 || swap_cnt !== 8'd2 || v !== 0) begin
            fails++; $display("FAIL rst_mid_resort: got done=%0d cmp=%0d swap=%0d viol=%0d, want 8/6/2/0",
                              dc, cmp_cnt, swap_cnt, v);
        end
        @(negedge clk);
        tests++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== 32'h00010203) begin
            fails++; $display("FAIL rst_mid_data: got %h, want 00010203", {mem[0], mem[1], mem[2], mem[3]});
        end
    endtask

    task automatic test_start_held;
        int dc, v;
        load4(8'd3, 8'd1, 8'd2, 8'd0);
        do_sort(1'b1, dc, v);
        tests++;
        if (dc !== 8 || cmp_cnt !== 8'd6 || v !== 0) begin
            fails++; $display("FAIL held_no_restart: got done=%0d cmp=%0d viol=%0d, want 8/6/0", dc, cmp_cnt, v);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL held_done_ignored: busy=%b done=%b after DONE, want 0/0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || i_ld !== 1'b1 || cmp_cnt !== 8'd0) begin
            fails++; $display("FAIL held_idle_accept: busy=%b i_ld=%b cmp=%0d, want 1/1/0", busy, i_ld, cmp_cnt);
        end
        dc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) begin dc = k; break; end
        end
        tests++;
        if (dc < 0 || cmp_cnt !== 8'd3) begin
            fails++; $display("FAIL held_second_sort: got done_seen=%0d cmp=%0d, want >=0/3", dc, cmp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sorted();
        test_duplicates();
        test_unsigned();
        test_len2();
        test_reset_mid();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
